fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Decoupling buffer between the fetch sub-units (instruction cache / local memory) and decode. It records the PC of every request issued to a fetch sub-unit and pairs each in-order response with its PC. It holds up to DEPTH issued-or-returned instructions and presents them to decode through a valid/ready handshake. A flush discards all buffered and outstanding state in one cycle.

## Interface
- DEPTH, default FETCH_BUFFER_DEPTH (4): entries; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  fetch flush (branch mispredict, exception, fence.i)
- req_issue  in  1  request issued to a fetch sub-unit this cycle (new_request); legal only when can_issue=1
- req_pc  in  32  PC of the issued request
- rsp_valid  in  1  sub-unit data_valid; responses arrive in issue order
- rsp_data  in  32  sub-unit data_out
- can_issue  out  1  buffer can accept one more request
- out_valid  out  1  head instruction available to decode
- out_pc  out  32  head PC
- out_instr  out  32  head instruction
- out_ready  in  1  decode consumes head when out_valid & out_ready
- outstanding  out  $clog2(DEPTH)+1  requests issued but not yet responded (debug/perf)

## Operation
- Circular buffer of DEPTH entries {pc, instr}, three pointers of width $clog2(DEPTH)+1 with MSB as wrap bit: alloc (tail), fill, head.
- Issue: req_issue & ~flush writes req_pc at alloc and increments alloc.
- Response: rsp_valid & ~flush writes rsp_data at fill and increments fill.
- Pop: out_valid & out_ready & ~flush increments head.
- can_issue = (alloc − head) < DEPTH. It is registered-state only and has no combinational path from out_ready, so a pop in the same cycle does not free a slot until the next cycle.
- out_valid = (fill ≠ head). out_pc and out_instr come from the entry at head.
- outstanding = alloc − fill.
- Issue, response and pop are independent and all may occur in one cycle, including on the same entry when the buffer is full-then-draining.
- Flush: alloc, fill and head all go to 0 on the next edge. Issue, response and pop in the flush cycle are ignored.
- Response contract: the sub-unit produces no responses for pre-flush requests after the flush cycle.
- Errors, checked by assertions with no recovery logic:
  - rsp_valid with outstanding=0.
  - req_issue with can_issue=0.
- Reset clears the pointers and the entry storage. Reset values: out_valid=0, can_issue=1, out_pc=0, out_instr=0, outstanding=0. An assertion mid-operation drops all contents immediately (asynchronous).

## Timing
- Response in cycle N gives out_valid=1 with that instruction in cycle N+1. No same-cycle bypass.
- Pop in cycle N presents the next filled entry at the head in N+1.
- Issue in cycle N: outstanding increments and can_issue updates in N+1.
- Flush in cycle N: out_valid=0, can_issue=1, outstanding=0 in N+1.
- Full: alloc−head=DEPTH gives can_issue=0.
- Empty: fill=head gives out_valid=0.
- Wrap-around: alloc−fill and alloc−head use modular subtraction at pointer width; the wrap bit distinguishes full from empty.

## Structure
- taiga_config: FETCH_BUFFER_DEPTH.
- taiga_types: fetch_buffer_entry_t {logic [31:0] pc; logic [31:0] instr;}.
- One sub-module, fetch_buffer_ptr: wrap-bit pointer with increment and synchronous clear (flush) plus async reset. Instantiated three times.
- Storage is an array of fetch_buffer_entry_t in registers. DEPTH is small, so there is no BRAM.

## Test plan
- Single fetch: issue pc=0x100, response 0x00000013 two cycles later → out_valid next cycle with out_pc=0x100, out_instr=0x13; outstanding goes 1→0.
- Fill to full with DEPTH=4 and out_ready=0: issue 0x0,0x4,0x8,0xC → can_issue=0 after the 4th issue. Pop one → can_issue=1 the following cycle, not the same cycle.
- Simultaneous events: issue, response and pop in one cycle for 20 back-to-back fetches across pointer wrap → decode receives PCs 0x0..0x4C in order with matching data, and there are no bubbles while responses are continuous.
- Flush with 2 outstanding and 1 filled: flush asserted together with rsp_valid → the next cycle has out_valid=0, outstanding=0, can_issue=1, and the flush-cycle response is not delivered. New issue 0x200 and its response are delivered correctly.
- Async reset asserted mid-burst between clock edges → outputs reach their reset values before the next edge. Operation resumes correctly after deassertion.
- Random backpressure on out_ready (50%) with random sub-unit latency 1–8 cycles over 1000 fetches → scoreboard matches every {pc, instr} pair and no assertions fire.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// Shared configuration and types for the fetch buffer.
package fetch_buffer_pkg;

  // Default number of buffered fetches between the fetch sub-units and decode.
  localparam int FETCH_BUFFER_DEPTH = 4;

  // One buffered fetch: the PC is recorded at issue and the instruction at response.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_buffer_entry_t;

endpackage

// File: rtl/fetch_buffer_ptr.sv
// Wrap-bit circular-buffer pointer: increments by one, cleared by flush or reset.
module fetch_buffer_ptr
  import fetch_buffer_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  // Pointer register; the MSB is the wrap bit that separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: pairs in-order sub-unit responses with their issued PCs and
// hands them to decode over a valid/ready handshake.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FETCH_BUFFER_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    req_issue,
  input  logic [31:0]             req_pc,
  input  logic                    rsp_valid,
  input  logic [31:0]             rsp_data,
  output logic                    can_issue,
  output logic                    out_valid,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_instr,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  outstanding
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] occupancy;
  logic [PW-1:0] filled;

  logic          issue_en;
  logic          fill_en;
  logic          pop_en;

  fetch_buffer_entry_t entries [DEPTH];

  // A flush cycle ignores every other event; the pointers simply clear.
  assign issue_en = req_issue & ~flush;
  assign fill_en  = rsp_valid & ~flush;
  assign pop_en   = out_valid & out_ready & ~flush;

  // Tail: next slot to receive an issued PC.
  fetch_buffer_ptr #(.W(PW)) u_alloc_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .inc   (issue_en),
    .value (alloc_ptr)
  );

  // Next slot to receive a response, always between head and alloc.
  fetch_buffer_ptr #(.W(PW)) u_fill_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .inc   (fill_en),
    .value (fill_ptr)
  );

  // Oldest filled entry presented to decode.
  fetch_buffer_ptr #(.W(PW)) u_head_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .inc   (pop_en),
    .value (head_ptr)
  );

  // Modular differences at pointer width; the wrap bit keeps full distinct from empty.
  assign occupancy   = alloc_ptr - head_ptr;
  assign filled      = fill_ptr - head_ptr;
  assign outstanding = alloc_ptr - fill_ptr;

  // can_issue depends only on registered pointers, so a same-cycle pop does not free a slot.
  assign can_issue = (occupancy < PW'(DEPTH));
  assign out_valid = (fill_ptr != head_ptr);
  assign out_pc    = entries[head_ptr[IW-1:0]].pc;
  assign out_instr = entries[head_ptr[IW-1:0]].instr;

  // Entry storage: PC written at issue, instruction written at response; reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (issue_en) begin
        entries[alloc_ptr[IW-1:0]].pc <= req_pc;
      end
      if (fill_en) begin
        entries[fill_ptr[IW-1:0]].instr <= rsp_data;
      end
    end
  end

  // Protocol errors from the fetch sub-units; no recovery logic exists for them.
  a_rsp_without_request : assert property (
    @(posedge clk) disable iff (rst) rsp_valid |-> (outstanding != '0)
  ) else $error("fetch_buffer: response with no outstanding request");

  a_issue_when_full : assert property (
    @(posedge clk) disable iff (rst) req_issue |-> can_issue
  ) else $error("fetch_buffer: request issued while buffer full");

  // Structural invariants: head <= fill <= alloc, never more than DEPTH apart.
  a_occupancy_bound : assert property (
    @(posedge clk) disable iff (rst) occupancy <= PW'(DEPTH)
  ) else $error("fetch_buffer: occupancy exceeds depth");

  a_fill_order : assert property (
    @(posedge clk) disable iff (rst) filled <= occupancy
  ) else $error("fetch_buffer: fill pointer passed alloc pointer");

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: directed scenarios plus a randomised
// latency/backpressure run.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_issue = 1'b0;
  logic [31:0] req_pc = '0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        can_issue;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;
  logic [2:0]  outstanding;

  int checks = 0;
  int errors = 0;

  fetch_buffer_entry_t exp_q[$];
  logic [31:0]         pend_q[$];

  fetch_buffer #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_issue   (req_issue),
    .req_pc      (req_pc),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .can_issue   (can_issue),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready),
    .outstanding (outstanding)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and update the reference model of what decode must see.
  task automatic drive(input logic iss, input logic [31:0] pc, input logic rv,
                       input logic [31:0] d, input logic rdy, input logic fl);
    fetch_buffer_entry_t e;
    req_issue = iss;
    req_pc    = pc;
    rsp_valid = rv;
    rsp_data  = d;
    out_ready = rdy;
    flush     = fl;
    if (fl) begin
      pend_q.delete();
      exp_q.delete();
    end else begin
      if (rv && pend_q.size() != 0) begin
        e.pc    = pend_q.pop_front();
        e.instr = d;
        exp_q.push_back(e);
      end
      if (iss) pend_q.push_back(pc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic iss, input logic [31:0] pc, input logic rv,
                     input logic [31:0] d, input logic rdy, input logic fl);
    drive(iss, pc, rv, d, rdy, fl);
    step();
  endtask

  // Monitor: every handshake at decode pops the scoreboard and compares the pair.
  always @(negedge clk) begin
    fetch_buffer_entry_t e;
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got pc 0x%08h instr 0x%08h expected nothing", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int issued;
    int responded;
    int cyc_n;
    int last_due;
    int lat;
    int due_q[$];
    logic iss;
    logic rv;
    logic rdy;
    logic [31:0] pc;
    logic [31:0] d;

    // Reset values
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_can_issue", 32'(can_issue), 32'd1);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single fetch
    cyc(1, 32'h100, 0, 0, 1, 0);
    check("t1_outstanding_1", 32'(outstanding), 32'd1);
    check("t1_no_valid_yet", 32'(out_valid), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 32'h0000_0013, 1, 0);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_outstanding_0", 32'(outstanding), 32'd0);
    check("t1_head_pc", out_pc, 32'h100);
    cyc(0, 0, 0, 0, 1, 0);
    check("t1_empty", 32'(out_valid), 32'd0);

    // Fill to full with decode stalled
    for (int k = 0; k < 4; k++) begin
      cyc(1, 32'(4 * k), 0, 0, 0, 0);
      check("t2_can_issue", 32'(can_issue), (k == 3) ? 32'd0 : 32'd1);
    end
    check("t2_outstanding_4", 32'(outstanding), 32'd4);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 32'h1000 + 32'(k), 0, 0);
    check("t2_outstanding_0", 32'(outstanding), 32'd0);
    check("t2_still_full", 32'(can_issue), 32'd0);
    drive(0, 0, 0, 0, 1, 0);
    #1;
    check("t2_pop_cycle_can_issue", 32'(can_issue), 32'd0);
    step();
    check("t2_after_pop_can_issue", 32'(can_issue), 32'd1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 0);
    check("t2_drained", 32'(out_valid), 32'd0);

    // Issue, response and pop together across pointer wrap
    cyc(1, 32'h0, 0, 0, 1, 0);
    for (int k = 1; k <= 20; k++) begin
      cyc((k < 20), 32'(4 * k), 1, 32'hC0DE_0000 | 32'(4 * (k - 1)), 1, 0);
      check("t3_no_bubble", 32'(out_valid), 32'd1);
    end
    cyc(0, 0, 0, 0, 1, 0);
    check("t3_drained", 32'(out_valid), 32'd0);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Flush with two outstanding and one filled, response in the flush cycle
    cyc(1, 32'h300, 0, 0, 0, 0);
    cyc(1, 32'h304, 0, 0, 0, 0);
    cyc(1, 32'h308, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'hAAAA_0300, 0, 0);
    check("t4_pre_outstanding", 32'(outstanding), 32'd2);
    check("t4_pre_valid", 32'(out_valid), 32'd1);
    cyc(1, 32'h999, 1, 32'hDEAD_BEEF, 1, 1);
    check("t4_flush_valid", 32'(out_valid), 32'd0);
    check("t4_flush_outstanding", 32'(outstanding), 32'd0);
    check("t4_flush_can_issue", 32'(can_issue), 32'd1);
    cyc(1, 32'h200, 0, 0, 1, 0);
    cyc(0, 0, 1, 32'h1122_3344, 1, 0);
    check("t4_new_valid", 32'(out_valid), 32'd1);
    cyc(0, 0, 0, 0, 1, 0);
    check("t4_new_drained", 32'(out_valid), 32'd0);

    // Asynchronous reset between clock edges
    cyc(1, 32'h400, 0, 0, 0, 0);
    cyc(1, 32'h404, 0, 0, 0, 0);
    cyc(1, 32'h408, 1, 32'h0000_4400, 0, 0);
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    pend_q.delete();
    exp_q.delete();
    #1;
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_can_issue", 32'(can_issue), 32'd1);
    check("t5_rst_out_pc", out_pc, 32'd0);
    check("t5_rst_out_instr", out_instr, 32'd0);
    check("t5_rst_outstanding", 32'(outstanding), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 32'h500, 0, 0, 1, 0);
    cyc(0, 0, 1, 32'h0000_0055, 1, 0);
    check("t5_resume_valid", 32'(out_valid), 32'd1);
    cyc(0, 0, 0, 0, 1, 0);

    // Random latency 1..8 and 50% decode backpressure over 1000 fetches
    issued    = 0;
    responded = 0;
    cyc_n     = 0;
    last_due  = 0;
    while ((responded < 1000 || exp_q.size() != 0) && cyc_n < 20000) begin
      iss = (issued < 1000) && can_issue && ($urandom_range(0, 3) != 0);
      rv  = (due_q.size() != 0) && (due_q[0] <= cyc_n);
      rdy = 1'($urandom_range(0, 1));
      pc  = 32'h1_0000 + 32'(4 * issued);
      d   = $urandom;
      if (rv) begin
        void'(due_q.pop_front());
        responded++;
      end
      if (iss) begin
        lat = $urandom_range(1, 8);
        last_due = (cyc_n + lat > last_due) ? cyc_n + lat : last_due + 1;
        due_q.push_back(last_due);
        issued++;
      end
      cyc(iss, pc, rv, d, rdy, 0);
      cyc_n++;
    end
    if (cyc_n >= 20000) begin
      checks++;
      errors++;
      $display("FAIL t6_timeout: got %0d responses expected 1000", responded);
    end
    check("t6_all_responded", 32'(responded), 32'd1000);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);
    check("t6_final_valid", 32'(out_valid), 32'd0);
    check("t6_final_outstanding", 32'(outstanding), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
